// File: rtl/seq_ram.sv
// seq_ram: parametrised synchronous RAM with a host write port, a handshaked host read port
// and an address-sweep engine streaming onto ram_out. Optional macro SEQ_RAM_CLEAR_EN zeroes the array after reset.
module seq_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              sweep_start,
  input  logic [ADDR_W-1:0] sweep_first,
  input  logic [ADDR_W-1:0] sweep_last,
  output logic              sweep_busy,
  output logic              sweep_done,
  output logic [DATA_W-1:0] ram_out,
  output logic              ram_out_valid
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1
`ifdef SEQ_RAM_CLEAR_EN
    , CLEAR = 2'd2
`endif
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] sweep_addr;
  logic [ADDR_W-1:0] sweep_left;
  logic [ADDR_W-1:0] sweep_span_c;
`ifdef SEQ_RAM_CLEAR_EN
  logic [ADDR_W-1:0] clr_cnt;
`endif

  // Span is N-1; the ADDR_W-bit subtraction gives the wrap-through-zero behaviour for free.
  assign sweep_span_c = sweep_last - sweep_first;
  assign rd_ready     = (state == IDLE) && !sweep_start;

  // Storage write port; reads elsewhere see the pre-edge contents (read-first).
  always_ff @(posedge clock) begin
`ifdef SEQ_RAM_CLEAR_EN
    if (state == CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
`else
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
`endif
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      ram_out       <= '0;
      ram_out_valid <= 1'b0;
      rd_data       <= '0;
      rd_valid      <= 1'b0;
      sweep_done    <= 1'b0;
      sweep_addr    <= '0;
      sweep_left    <= '0;
`ifdef SEQ_RAM_CLEAR_EN
      state         <= CLEAR;
      sweep_busy    <= 1'b1;
      clr_cnt       <= '0;
`else
      state         <= IDLE;
      sweep_busy    <= 1'b0;
`endif
    end else begin
      ram_out_valid <= 1'b0;
      rd_valid      <= 1'b0;
      sweep_done    <= 1'b0;
      case (state)
        IDLE: begin
          if (sweep_start) begin
            ram_out       <= mem[sweep_first];
            ram_out_valid <= 1'b1;
            sweep_addr    <= sweep_first + ADDR_W'(1);
            sweep_left    <= sweep_span_c;
            if (sweep_span_c == '0) begin
              sweep_done <= 1'b1;
            end else begin
              state      <= SWEEP;
              sweep_busy <= 1'b1;
            end
          end else if (rd_req) begin
            rd_data  <= mem[rd_addr];
            rd_valid <= 1'b1;
          end
        end
        SWEEP: begin
          ram_out       <= mem[sweep_addr];
          ram_out_valid <= 1'b1;
          sweep_addr    <= sweep_addr + ADDR_W'(1);
          sweep_left    <= sweep_left - ADDR_W'(1);
          // sweep_left counts words still owed including this one.
          if (sweep_left == ADDR_W'(1)) begin
            sweep_done <= 1'b1;
            sweep_busy <= 1'b0;
            state      <= IDLE;
          end
        end
`ifdef SEQ_RAM_CLEAR_EN
        CLEAR: begin
          clr_cnt <= clr_cnt + ADDR_W'(1);
          if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
            sweep_busy <= 1'b0;
            state      <= IDLE;
          end
        end
`endif
        default: begin
          sweep_busy <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_ram.sv
// Self-checking bench for seq_ram: randomized sweeps, host reads and writes against a
// behavioural memory model; also exercises the SEQ_RAM_CLEAR_EN build when defined.
module tb_seq_ram;

  localparam int DEPTH = 16;

  logic       clock = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_req;
  logic [3:0] rd_addr;
  logic       rd_ready;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       sweep_start;
  logic [3:0] sweep_first;
  logic [3:0] sweep_last;
  logic       sweep_busy;
  logic       sweep_done;
  logic [7:0] ram_out;
  logic       ram_out_valid;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] ref_mem [DEPTH];

  always #5 clock = ~clock;

  seq_ram #(.DATA_W(8), .ADDR_W(4)) dut (
    .clock(clock), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .sweep_start(sweep_start), .sweep_first(sweep_first), .sweep_last(sweep_last),
    .sweep_busy(sweep_busy), .sweep_done(sweep_done),
    .ram_out(ram_out), .ram_out_valid(ram_out_valid)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if (ram_out !== 8'h00) begin miscompares++; $display("FAIL reset_ram_out: got %h want 00", ram_out); end
    vectors++;
    if (ram_out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_ram_out_valid: got %b want 0", ram_out_valid); end
    vectors++;
    if (rd_data !== 8'h00 || rd_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_rd: got data %h valid %b want 00/0", rd_data, rd_valid);
    end
    vectors++;
    if (sweep_done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", sweep_done); end
`ifdef SEQ_RAM_CLEAR_EN
    // Clear phase: writes attempted here must be dropped.
    for (int i = 0; i < DEPTH; i++) begin
      vectors++;
      if (sweep_busy !== 1'b1 || rd_ready !== 1'b0) begin
        miscompares++; $display("FAIL clear_busy c=%0d: got busy %b ready %b want 1/0", i, sweep_busy, rd_ready);
      end
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = 8'hFF;
      tick();
    end
    wr_en = 1'b0;
    #1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
    vectors++;
    if (sweep_busy !== 1'b0 || rd_ready !== 1'b1) begin
      miscompares++; $display("FAIL clear_end: got busy %b ready %b want 0/1", sweep_busy, rd_ready);
    end
    run_sweep(4'd0, 4'd15, 1'b0, 4'd0, 1'b0, -1, 4'd0, 8'd0);
`else
    vectors++;
    if (sweep_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", sweep_busy); end
`endif
  endtask

  // Expected word k comes from the model as it stands before the edge that reads it.
  task automatic run_sweep(input logic [3:0] s_first, input logic [3:0] s_last,
                           input bit hold_rd, input logic [3:0] rd_a,
                           input bit rand_wr, input int force_k,
                           input logic [3:0] force_a, input logic [7:0] force_d);
    int n;
    logic [7:0] exp_word;
    logic [7:0] exp_rd;
    n = ((int'(s_last) - int'(s_first) + DEPTH) % DEPTH) + 1;
    sweep_first = s_first; sweep_last = s_last; sweep_start = 1'b1;
    rd_req = hold_rd; rd_addr = rd_a;
    #1;
    vectors++;
    if (rd_ready !== 1'b0) begin miscompares++; $display("FAIL ready_at_start: got %b want 0", rd_ready); end
    for (int k = 0; k < n; k++) begin
      wr_en = 1'b0;
      if (k == force_k) begin
        wr_en = 1'b1; wr_addr = force_a; wr_data = force_d;
      end else if (rand_wr && $urandom_range(0, 1) == 1) begin
        wr_en = 1'b1; wr_addr = 4'($urandom_range(0, 15)); wr_data = 8'($urandom);
      end
      exp_word = ref_mem[(int'(s_first) + k) % DEPTH];
      tick();
      if (wr_en) ref_mem[wr_addr] = wr_data;
      wr_en = 1'b0;
      vectors++;
      if (ram_out_valid !== 1'b1 || ram_out !== exp_word) begin
        miscompares++; $display("FAIL sweep_word k=%0d: got %h valid %b want %h valid 1", k, ram_out, ram_out_valid, exp_word);
      end
      vectors++;
      if (sweep_done !== (k == n - 1) || sweep_busy !== (k != n - 1)) begin
        miscompares++; $display("FAIL sweep_flags k=%0d/%0d: got done %b busy %b", k, n, sweep_done, sweep_busy);
      end
      vectors++;
      if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL rd_valid_in_sweep k=%0d: got %b want 0", k, rd_valid); end
      sweep_first = 4'($urandom_range(0, 15));
      sweep_last  = 4'($urandom_range(0, 15));
      sweep_start = rand_wr && (k < n - 1) && ($urandom_range(0, 1) == 1);
      #1;
      vectors++;
      if (rd_ready !== (k == n - 1)) begin
        miscompares++; $display("FAIL ready_in_sweep k=%0d: got %b want %b", k, rd_ready, (k == n - 1));
      end
    end
    exp_rd = ref_mem[rd_a];
    tick();
    rd_req = 1'b0;
    vectors++;
    if (ram_out_valid !== 1'b0 || sweep_done !== 1'b0 || sweep_busy !== 1'b0) begin
      miscompares++; $display("FAIL sweep_end: got valid %b done %b busy %b want 0/0/0", ram_out_valid, sweep_done, sweep_busy);
    end
    vectors++;
    if (rd_valid !== hold_rd || (hold_rd && rd_data !== exp_rd)) begin
      miscompares++; $display("FAIL held_read: got valid %b data %h want valid %b data %h", rd_valid, rd_data, hold_rd, exp_rd);
    end
  endtask

  task automatic host_read(input logic [3:0] a, input bit col);
    logic [7:0] exp_rd;
    rd_req = 1'b1; rd_addr = a;
    if (col) begin wr_en = 1'b1; wr_addr = a; wr_data = 8'($urandom); end
    exp_rd = ref_mem[a];
    #1;
    vectors++;
    if (rd_ready !== 1'b1) begin miscompares++; $display("FAIL host_ready: got %b want 1", rd_ready); end
    tick();
    if (wr_en) ref_mem[wr_addr] = wr_data;
    wr_en = 1'b0; rd_req = 1'b0;
    vectors++;
    if (rd_valid !== 1'b1 || rd_data !== exp_rd) begin
      miscompares++; $display("FAIL host_read a=%0d: got %h valid %b want %h valid 1", a, rd_data, rd_valid, exp_rd);
    end
    tick();
    vectors++;
    if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL host_pulse: got %b want 0", rd_valid); end
  endtask

  task automatic test_fill_full();
    for (int i = 0; i < DEPTH; i++) begin
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = 8'(8'h10 + i);
      tick();
      ref_mem[i] = 8'(8'h10 + i);
    end
    wr_en = 1'b0;
    run_sweep(4'd0, 4'd15, 1'b0, 4'd0, 1'b0, -1, 4'd0, 8'd0);
  endtask

  task automatic test_wrap();
    run_sweep(4'd14, 4'd1, 1'b0, 4'd0, 1'b0, -1, 4'd0, 8'd0);
    run_sweep(4'd9, 4'd9, 1'b0, 4'd0, 1'b0, -1, 4'd0, 8'd0);
  endtask

  task automatic test_read_blocked();
    run_sweep(4'd0, 4'd15, 1'b1, 4'd5, 1'b0, -1, 4'd0, 8'd0);
  endtask

  task automatic test_collision();
    run_sweep(4'd0, 4'd15, 1'b0, 4'd0, 1'b0, 3, 4'd3, 8'hAA);
    host_read(4'd3, 1'b0);
    host_read(4'd7, 1'b1);
  endtask

  task automatic test_reset_mid();
    sweep_first = 4'd0; sweep_last = 4'd15; sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    for (int k = 1; k < 6; k++) tick();
    vectors++;
    if (ram_out_valid !== 1'b1 || ram_out !== ref_mem[5]) begin
      miscompares++; $display("FAIL pre_reset_word: got %h valid %b want %h valid 1", ram_out, ram_out_valid, ref_mem[5]);
    end
    reset = 1'b1; sweep_start = 1'b1;
    tick();
    reset = 1'b0; sweep_start = 1'b0;
    vectors++;
    if (ram_out_valid !== 1'b0 || ram_out !== 8'h00 || sweep_done !== 1'b0) begin
      miscompares++; $display("FAIL mid_reset: got out %h valid %b done %b want 00/0/0", ram_out, ram_out_valid, sweep_done);
    end
`ifdef SEQ_RAM_CLEAR_EN
    vectors++;
    if (sweep_busy !== 1'b1) begin miscompares++; $display("FAIL mid_reset_busy: got %b want 1", sweep_busy); end
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
`else
    vectors++;
    if (sweep_busy !== 1'b0) begin miscompares++; $display("FAIL mid_reset_busy: got %b want 0", sweep_busy); end
`endif
    for (int i = 0; i < 20; i++) begin
      tick();
      vectors++;
      if (ram_out_valid !== 1'b0 || sweep_done !== 1'b0) begin
        miscompares++; $display("FAIL post_reset_idle c=%0d: got valid %b done %b want 0/0", i, ram_out_valid, sweep_done);
      end
    end
    run_sweep(4'd0, 4'd15, 1'b0, 4'd0, 1'b0, -1, 4'd0, 8'd0);
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_rd;
    for (int i = 0; i < 8; i++) begin
      rd_req = 1'b1; rd_addr = 4'($urandom_range(0, 15));
      exp_rd = ref_mem[rd_addr];
      tick();
      vectors++;
      if (rd_valid !== 1'b1 || rd_data !== exp_rd) begin
        miscompares++; $display("FAIL b2b_read i=%0d: got %h valid %b want %h valid 1", i, rd_data, rd_valid, exp_rd);
      end
    end
    rd_req = 1'b0;
    tick();
    vectors++;
    if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_end: got %b want 0", rd_valid); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        host_read(4'($urandom_range(0, 15)), $urandom_range(0, 1) == 1);
      end else begin
        run_sweep(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom_range(0, 1) == 1,
                  4'($urandom_range(0, 15)), 1'b1, -1, 4'd0, 8'd0);
      end
    end
  endtask

  initial begin
    reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_req = 1'b0; rd_addr = '0; sweep_start = 1'b0; sweep_first = '0; sweep_last = '0;
    test_reset();
    test_fill_full();
    test_wrap();
    test_read_blocked();
    test_collision();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
